carregador_rom: RTL and testbench

Program loader for the instruction ROM: the write side of the memory the fetch stage reads through its ROM sink enables. The loader accepts a byte stream over a valid/ready handshake, packs the bytes into 16-bit instruction words, and writes them sequentially into the instruction ROM's write port. While a load is in progress it holds the processor, so fetch never reads a half-written program.

---
 rtl/carregador_rom.sv | 171 +++++++++++++++++
 tb/tb_carregador_rom.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_rom.sv
// Instruction ROM program loader: unpacks a byte stream (count, then 16-bit words) into ROM writes.
// Optional trailing XOR checksum byte when CARREGADOR_CHECKSUM_EN is defined.
module carregador_rom #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned MAX_PALAVRAS = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inicio,
    input  logic [7:0]        byte_entrada,
    input  logic              byte_valido,
    output logic              byte_pronto,
    output logic              rom_escrita_hab,
    output logic [ADDR_W-1:0] rom_endereco,
    output logic [15:0]       rom_dado,
    output logic              segura_cpu,
    output logic              carga_concluida,
    output logic              erro
);

    typedef enum logic [3:0] {
        StOcioso,
        StContH,
        StContL,
        StDadoH,
        StDadoL,
        StEscreve,
        StFim,
        StErro
`ifdef CARREGADOR_CHECKSUM_EN
        , StCheck
`endif
    } estado_t;

    // State entered once the last word has been written (or on an empty program).
`ifdef CARREGADOR_CHECKSUM_EN
    localparam estado_t StPosDados = StCheck;
`else
    localparam estado_t StPosDados = StFim;
`endif

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [15:0]       restante_q, restante_d;
    logic [7:0]        alto_q, alto_d;
    logic [15:0]       dado_q, dado_d;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0]        acc_q, acc_d;
`endif

    logic        transfere;
    logic [15:0] contagem;

    assign transfere    = byte_valido & byte_pronto;
    assign contagem     = {alto_q, byte_entrada};
    assign rom_endereco = endereco_q;
    assign rom_dado     = dado_q;

    always_comb begin
        byte_pronto     = 1'b0;
        rom_escrita_hab = 1'b0;
        carga_concluida = 1'b0;
        erro            = 1'b0;
        segura_cpu      = 1'b1;
        unique case (estado_q)
            StOcioso:                           segura_cpu = 1'b0;
            StContH, StContL, StDadoH, StDadoL: byte_pronto = 1'b1;
            StEscreve:                          rom_escrita_hab = 1'b1;
            StFim: begin
                carga_concluida = 1'b1;
                segura_cpu      = 1'b0;
            end
            StErro:                             erro = 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
            StCheck:                            byte_pronto = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        restante_d = restante_q;
        alto_d     = alto_q;
        dado_d     = dado_q;
`ifdef CARREGADOR_CHECKSUM_EN
        acc_d      = acc_q;
        if (transfere && estado_q != StCheck) begin
            acc_d = acc_q ^ byte_entrada;
        end
`endif
        unique case (estado_q)
            StOcioso, StFim, StErro: begin
                if (inicio) begin
                    estado_d   = StContH;
                    endereco_d = '0;
`ifdef CARREGADOR_CHECKSUM_EN
                    acc_d      = '0;
`endif
                end
            end
            StContH: begin
                if (transfere) begin
                    alto_d   = byte_entrada;
                    estado_d = StContL;
                end
            end
            StContL: begin
                if (transfere) begin
                    restante_d = contagem;
                    if ({16'd0, contagem} > MAX_PALAVRAS) begin
                        estado_d = StErro;
                    end else if (contagem == 16'd0) begin
                        estado_d = StPosDados;
                    end else begin
                        estado_d = StDadoH;
                    end
                end
            end
            StDadoH: begin
                if (transfere) begin
                    alto_d   = byte_entrada;
                    estado_d = StDadoL;
                end
            end
            StDadoL: begin
                if (transfere) begin
                    dado_d   = {alto_q, byte_entrada};
                    estado_d = StEscreve;
                end
            end
            StEscreve: begin
                endereco_d = endereco_q + ADDR_W'(1);
                restante_d = restante_q - 16'd1;
                estado_d   = (restante_q == 16'd1) ? StPosDados : StDadoH;
            end
`ifdef CARREGADOR_CHECKSUM_EN
            StCheck: begin
                if (transfere) begin
                    estado_d = (byte_entrada == acc_q) ? StFim : StErro;
                end
            end
`endif
            default: estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= StOcioso;
            endereco_q <= '0;
            restante_q <= '0;
            alto_q     <= '0;
            dado_q     <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            restante_q <= restante_d;
            alto_q     <= alto_d;
            dado_q     <= dado_d;
`ifdef CARREGADOR_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_carregador_rom.sv
// Bench for carregador_rom: stream-level model predicts each ROM write and the final flags.
// Follows CARREGADOR_CHECKSUM_EN to add/verify the trailing checksum byte.
module tb_carregador_rom;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned MAX    = 256;
`ifdef CARREGADOR_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              inicio = 1'b0;
    logic [7:0]        byte_entrada = 8'h00;
    logic              byte_valido = 1'b0;
    logic              byte_pronto;
    logic              rom_escrita_hab;
    logic [ADDR_W-1:0] rom_endereco;
    logic [15:0]       rom_dado;
    logic              segura_cpu;
    logic              carga_concluida;
    logic              erro;

    carregador_rom #(
        .ADDR_W      (ADDR_W),
        .MAX_PALAVRAS(MAX)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .inicio         (inicio),
        .byte_entrada   (byte_entrada),
        .byte_valido    (byte_valido),
        .byte_pronto    (byte_pronto),
        .rom_escrita_hab(rom_escrita_hab),
        .rom_endereco   (rom_endereco),
        .rom_dado       (rom_dado),
        .segura_cpu     (segura_cpu),
        .carga_concluida(carga_concluida),
        .erro           (erro)
    );

    always #5 clock = ~clock;

    int erros = 0;
    int checagens = 0;

    // Stream currently being sent; the model derives every expectation from it.
    logic [7:0]  fluxo [0:1023];
    int          idx = 0;
    int          n_pal = 0;
    int          n_escritas = 0;
    bit          pend = 1'b0;
    logic [7:0]  pend_addr = 8'h00;
    logic [15:0] pend_dado = 16'h0000;
    logic [15:0] ultimo_dado = 16'h0000;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checagens++;
        if (atual !== esperado) begin
            erros++;
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
        end
    endtask

    // Per-cycle compare: byte k of the stream is consumed in order; a word's low byte
    // consumed at edge e must produce exactly one write, in the cycle after e.
    always @(negedge clock) begin
        if (!reset) begin
            chk("saidas em reset", {byte_pronto, rom_escrita_hab, segura_cpu, carga_concluida,
                                    erro, rom_endereco, rom_dado}, 32'd0);
            idx        = 0;
            pend       = 1'b0;
            n_escritas = 0;
        end else begin
            chk("escrita no ciclo previsto", rom_escrita_hab, pend);
            if (rom_escrita_hab) begin
                chk("endereco da escrita", rom_endereco, pend_addr);
                chk("dado da escrita", rom_dado, pend_dado);
                chk("pronto durante escrita", byte_pronto, 1'b0);
                n_escritas++;
                ultimo_dado = rom_dado;
            end
            if (carga_concluida) chk("segura em fim", {segura_cpu, erro}, 2'b00);
            if (erro) chk("segura em erro", {segura_cpu, carga_concluida}, 2'b10);
            pend = 1'b0;
            if (inicio && !byte_pronto && !rom_escrita_hab) begin
                idx        = 0;
                n_escritas = 0;
            end else if (byte_valido && byte_pronto) begin
                if (idx == 1) n_pal = int'({fluxo[0], byte_entrada});
                if (idx >= 3 && idx % 2 == 1 && (idx - 3) / 2 < n_pal && n_pal <= int'(MAX)) begin
                    pend      = 1'b1;
                    pend_addr = 8'((idx - 3) / 2);
                    pend_dado = {fluxo[idx-1], byte_entrada};
                end
                idx++;
            end
        end
    end

    task automatic inicio_pulso();
        @(posedge clock);
        #1 inicio = 1'b1;
        @(posedge clock);
        #1 inicio = 1'b0;
        chk("estado apos inicio", {byte_pronto, segura_cpu, carga_concluida, erro}, 4'b1100);
    endtask

    task automatic envia(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        byte_entrada = b;
        byte_valido  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = byte_pronto;
            @(posedge clock);
            #1;
        end
        chk("byte aceito no prazo", ok, 1'b1);
        if (gap > 0) begin
            int g = $urandom_range(0, gap);
            if (g > 0) begin
                byte_valido  = 1'b0;
                byte_entrada = 8'($urandom);
                repeat (g) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic fecha(input int tam_in, input bit ruim, output int tam_out);
        logic [7:0] x = 8'h00;
        tam_out = tam_in;
        if (CkEn) begin
            for (int i = 0; i < tam_in; i++) x ^= fluxo[i];
            fluxo[tam_in] = ruim ? ~x : x;
            tam_out = tam_in + 1;
        end
    endtask

    task automatic prepara(input int n, input bit ruim, output int tam);
        int t = 2;
        fluxo[0] = 8'(n >> 8);
        fluxo[1] = 8'(n);
        if (n <= int'(MAX)) begin
            for (int w = 0; w < n; w++) begin
                fluxo[t]   = 8'($urandom);
                fluxo[t+1] = 8'($urandom);
                t += 2;
            end
            fecha(t, ruim, t);
        end
        tam = t;
    endtask

    task automatic carga(input int tam, input int n, input int gap, input bit ruim);
        int  lim = (n > int'(MAX)) ? 2 : tam;
        bit  fim = 1'b0;
        inicio_pulso();
        for (int i = 0; i < lim; i++) envia(fluxo[i], gap);
        byte_valido = 1'b0;
        for (int i = 0; i < 20 && !fim; i++) begin
            @(negedge clock);
            #1;
            fim = carga_concluida | erro;
        end
        chk("carga terminou no prazo", fim, 1'b1);
        if (n > int'(MAX) || ruim) begin
            chk("flags de erro", {carga_concluida, erro, segura_cpu}, 3'b011);
            chk("escritas em erro", n_escritas, (n > int'(MAX)) ? 0 : n);
        end else begin
            chk("flags de sucesso", {carga_concluida, erro, segura_cpu}, 3'b100);
            chk("endereco final", rom_endereco, n % 256);
            chk("numero de escritas", n_escritas, n);
        end
    endtask

    initial begin
        int tam;
        int n;
        #2 reset = 1'b0;
        #1 chk("reset inicial", {byte_pronto, rom_escrita_hab, segura_cpu, carga_concluida, erro,
                                 rom_endereco, rom_dado}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Two words, with gaps.
        fluxo[0] = 8'h00; fluxo[1] = 8'h02; fluxo[2] = 8'h12;
        fluxo[3] = 8'h34; fluxo[4] = 8'hAB; fluxo[5] = 8'hCD;
        fecha(6, 1'b0, tam);
        if (CkEn) chk("checksum do modelo", fluxo[6], 8'h42);
        carga(tam, 2, 2, 1'b0);
        chk("ultimo dado escrito", ultimo_dado, 16'hABCD);
        chk("endereco apos duas palavras", rom_endereco, 8'd2);

        // A trailing byte offered in FIM must not be taken.
        byte_entrada = 8'h55;
        byte_valido  = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("byte extra recusado", byte_pronto, 1'b0);
        end
        byte_valido = 1'b0;
        chk("fim mantido", carga_concluida, 1'b1);

        // Empty program.
        fluxo[0] = 8'h00; fluxo[1] = 8'h00;
        fecha(2, 1'b0, tam);
        carga(tam, 0, 0, 1'b0);
        chk("vazio sem escrita", n_escritas, 0);

        // Oversize count, then restart clears the error.
        fluxo[0] = 8'h01; fluxo[1] = 8'h01;
        carga(2, 257, 0, 1'b0);
        chk("erro pendente", erro, 1'b1);
        inicio_pulso();

        // Already in CONT_H: this load's own inicio is ignored.
        prepara(5, 1'b0, tam);
        carga(tam, 5, 1, 1'b0);

        if (CkEn) begin
            fluxo[0] = 8'h00; fluxo[1] = 8'h01; fluxo[2] = 8'h12;
            fluxo[3] = 8'h34; fluxo[4] = 8'h27;
            carga(5, 1, 0, 1'b0);
            fluxo[4] = 8'h26;
            carga(5, 1, 0, 1'b1);
            chk("escrita antes do checksum ruim", n_escritas, 1);
        end

        // Reset after the first data byte.
        fluxo[0] = 8'h00; fluxo[1] = 8'h02; fluxo[2] = 8'h12;
        fluxo[3] = 8'h34; fluxo[4] = 8'hAB; fluxo[5] = 8'hCD;
        fecha(6, 1'b0, tam);
        inicio_pulso();
        envia(8'h00, 0);
        envia(8'h02, 0);
        envia(8'h12, 0);
        byte_valido = 1'b0;
        #2 reset = 1'b0;
        #1 chk("reset assincrono no meio", {byte_pronto, rom_escrita_hab, segura_cpu,
                                            carga_concluida, erro, rom_endereco, rom_dado}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        carga(tam, 2, 0, 1'b0);

        // Randomized loads, some with valid held high throughout.
        for (int i = 0; i < 8; i++) begin
            bit ruim;
            n    = $urandom_range(1, 24);
            ruim = CkEn && ($urandom_range(0, 3) == 0);
            prepara(n, ruim, tam);
            carga(tam, n, $urandom_range(0, 3), ruim);
        end

        // Full-size program: the address counter wraps back to 0.
        prepara(256, 1'b0, tam);
        carga(tam, 256, 0, 1'b0);

        n = $urandom_range(257, 600);
        prepara(n, 1'b0, tam);
        carga(tam, n, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", erros, checagens);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before 90000 cycles");
        $fatal(1);
    end

endmodule
